// File: rtl/booth_divider.sv
// booth_divider: sequential signed restoring divider, 2*WIDTH-bit dividend by WIDTH-bit divisor.
// Magnitudes are divided one quotient bit per cycle; signs, range and divide-by-zero are fixed up at the end.
module booth_divider #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_zero,
  output logic                 overflow
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH:0] HALF = (WIDTH+1)'(1) << (WIDTH-1);
  typedef enum logic [1:0] {IDLE, LOAD, CALC, FIX} state_t;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d, rem_q, rem_d, qm_q, qm_d;
  logic                 sa_q, sa_d, sb_q, sb_d, dz_q, dz_d, ovp_q, ovp_d;
  logic [WIDTH-1:0]     quotient_q, quotient_d, remainder_q, remainder_d;
  logic                 busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d, overflow_q, overflow_d;
  logic [2*WIDTH-1:0]   am;
  logic [WIDTH-1:0]     bm;
  logic [WIDTH:0]       t, lim;
  logic [WIDTH+1:0]     diff;
  logic                 ge, neg, ovf, bad;
  assign am   = sa_q ? -a_q : a_q;
  assign bm   = sb_q ? -b_q : b_q;
  assign t    = {rem_q, a_q[WIDTH-1]};
  assign diff = {1'b0, t} - {2'b0, b_q};
  assign ge   = ~diff[WIDTH+1];
  assign neg  = sa_q ^ sb_q;
  assign lim  = neg ? HALF : HALF - (WIDTH+1)'(1);
  assign ovf  = ovp_q | ({1'b0, qm_q} > lim);
  assign bad  = dz_q | ovf;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    rem_d       = rem_q;
    qm_d        = qm_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    dz_d        = dz_q;
    ovp_d       = ovp_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    overflow_d  = overflow_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        a_d     = dividend;
        b_d     = divisor;
        sa_d    = dividend[2*WIDTH-1];
        sb_d    = divisor[WIDTH-1];
        busy_d  = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        a_d     = am;
        b_d     = bm;
        rem_d   = am[2*WIDTH-1:WIDTH];
        qm_d    = '0;
        dz_d    = (bm == '0);
        ovp_d   = (am[2*WIDTH-1:WIDTH] >= bm);
        cnt_d   = CW'(WIDTH-1);
        state_d = CALC;
      end
      CALC: begin
        a_d     = a_q << 1;
        rem_d   = ge ? diff[WIDTH-1:0] : t[WIDTH-1:0];
        qm_d    = {qm_q[WIDTH-2:0], ge};
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == '0) ? FIX : CALC;
      end
      FIX: begin
        div_zero_d  = dz_q;
        overflow_d  = ~dz_q & ovf;
        quotient_d  = bad ? '0 : (neg ? -qm_q : qm_q);
        remainder_d = bad ? '0 : (sa_q ? -rem_q : rem_q);
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      qm_q        <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      dz_q        <= 1'b0;
      ovp_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rem_q       <= rem_d;
      qm_q        <= qm_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      dz_q        <= dz_d;
      ovp_q       <= ovp_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_booth_divider.sv
// tb_booth_divider: directed checks of booth_divider (WIDTH=8) with hand-computed results.
module tb_booth_divider;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy, done, div_zero, overflow;
  logic [7:0]  quotient, remainder;
  int          errors = 0;
  int          checks = 0;
  int          lat;
  int          npulse;
  booth_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(output int l);
    l = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        l = i;
        break;
      end
    end
  endtask
  task automatic do_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                       input logic [7:0] q, input logic [7:0] r, input logic dz, input logic ov);
    int l;
    start_op(a, b);
    wait_done(l);
    chk({tag, "_lat"}, l, 10);
    chk({tag, "_q"}, quotient, q);
    chk({tag, "_r"}, remainder, r);
    chk({tag, "_dz"}, div_zero, dz);
    chk({tag, "_ov"}, overflow, ov);
    chk({tag, "_busy"}, busy, 0);
    @(posedge clk);
    #1 chk({tag, "_pulse"}, done, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_ov", overflow, 0);
    rst = 1'b0;
    do_op("rt30_3", 16'd30, 8'd3, 8'd10, 8'd0, 0, 0);
    do_op("rt1000_10", 16'd1000, 8'd10, 8'd100, 8'd0, 0, 0);
    do_op("rt75_5", 16'd75, 8'd5, 8'd15, 8'd0, 0, 0);
    do_op("n75_5", 16'(-75), 8'd5, 8'hF1, 8'd0, 0, 0);
    do_op("p77_n10", 16'd77, 8'(-10), 8'hF9, 8'd7, 0, 0);
    do_op("n77_p10", 16'(-77), 8'd10, 8'hF9, 8'hF9, 0, 0);
    do_op("n77_n10", 16'(-77), 8'(-10), 8'd7, 8'hF9, 0, 0);
    do_op("n128_1", 16'(-128), 8'd1, 8'h80, 8'd0, 0, 0);
    do_op("p128_1", 16'd128, 8'd1, 8'd0, 8'd0, 0, 1);
    do_op("n32768_n1", 16'h8000, 8'hFF, 8'd0, 8'd0, 0, 1);
    do_op("p1000_3", 16'd1000, 8'd3, 8'd0, 8'd0, 0, 1);
    do_op("dz1234", 16'd1234, 8'd0, 8'd0, 8'd0, 1, 0);
    do_op("n77_n10b", 16'(-77), 8'(-10), 8'd7, 8'hF9, 0, 0);
    // Abort an operation mid-divide with an asynchronous reset between clock edges.
    start_op(16'd1000, 8'd10);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_q", quotient, 0);
    chk("arst_r", remainder, 0);
    chk("arst_dz", div_zero, 0);
    chk("arst_ov", overflow, 0);
    #2 rst = 1'b0;
    do_op("post_rst", 16'd75, 8'd5, 8'd15, 8'd0, 0, 0);
    @(negedge clk);
    dividend = 16'd30;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    wait_done(lat);
    chk("hold_lat1", lat, 10);
    chk("hold_q1", quotient, 10);
    wait_done(lat);
    start = 1'b0;
    chk("hold_lat2", lat, 11);
    chk("hold_q2", quotient, 10);
    repeat (2) @(posedge clk);
    do_op("prep", 16'd1000, 8'd10, 8'd100, 8'd0, 0, 0);
    start_op(16'd30, 8'd3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    dividend = 16'd1000;
    divisor  = 8'd10;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("ign_busy", busy, 1);
    wait_done(lat);
    chk("ign_lat", lat, 6);
    chk("ign_q", quotient, 10);
    chk("ign_r", remainder, 0);
    npulse = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      if (done) npulse++;
    end
    chk("ign_nodone", npulse, 0);
    chk("ign_q_hold", quotient, 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
